imm_assemble_reg: RTL and testbench
===================================

// Module: imm_assemble_reg
// PURPOSE
//  Downstream of the shift-by-8 upper-immediate stage. Captures the 16-bit upper value {imm8,8'h00}.
//  Merges it with the following low-byte immediate into one 16-bit constant for register-file writeback.
//  A lone low byte is zero-extended. A lone upper value is emitted after TIMEOUT cycles.
//  Output is a registered valid/ready slot.
// PARAMETERS
//  WIDTH    16  data width; fixed for this processor.
//  HALF     8   byte width; HALF = WIDTH/2.
//  TIMEOUT  4   max cycles HOLD waits for a low byte before emitting the upper value alone. Range 1..15.
// PORTS
//  clk          in   1      system clock, rising edge
//  reset_n      in   1      asynchronous active-low reset
//  flush        in   1      synchronous abandon of partial and pending constants (branch/trap)
//  upper_valid  in   1      upper_in is presented
//  upper_in     in   WIDTH  value from the shift-by-8 stage; only [15:8] is used, [7:0] is ignored
//  lower_valid  in   1      lower_in is presented
//  lower_in     in   HALF   low-byte immediate
//  in_ready     out  1      inputs are accepted this cycle; = !out_valid | out_ready
//  out_valid    out  1      out_data holds a complete constant
//  out_data     out  WIDTH  assembled constant
//  out_ready    in   1      consumer takes out_data this cycle
//  busy         out  1      state == HOLD
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, held=0, cnt=0, out_valid=0, out_data=0, busy=0.
//  - Handshakes:
//    - Input accept = x_valid & in_ready; unaccepted inputs are ignored, not queued.
//    - Output transfer = out_valid & out_ready.
//    - out_valid is held, with out_data stable, until the transfer occurs.
//  - FSM, IDLE:
//    - upper and lower both accepted -> emit {upper_in[15:8],lower_in}; stay IDLE.
//    - upper only -> held <= upper_in[15:8], cnt <= 0; go to HOLD.
//    - lower only -> emit {8'h00,lower_in}; stay IDLE.
//  - FSM, HOLD:
//    - lower only -> emit {held,lower_in}; go to IDLE.
//    - upper and lower -> emit {upper_in[15:8],lower_in}. The incoming upper wins and held is discarded. Go to IDLE.
//    - upper only -> held <= upper_in[15:8], cnt <= 0 (last wins); stay HOLD.
//    - no input -> cnt++.
//      - At cnt==TIMEOUT-1 with the output slot free (in_ready), emit {held,8'h00} and go to IDLE.
//      - If the slot is not free, cnt saturates and emission waits.
//  - Emit: out_data and out_valid are registered on the next edge. Latency is 1 cycle from the completing accept to out_valid=1.
//  - Back-to-back:
//    - A transfer and a new emit in the same cycle keep out_valid=1 and load the new data.
//    - A transfer with no emit clears out_valid.
//  - flush (priority over all else):
//    - Next edge: state=IDLE, cnt=0, out_valid=0. Inputs presented that cycle are dropped.
//    - out_data keeps its value (don't-care).
//  - Reset mid-HOLD or with out_valid=1: all state is lost immediately; no emission.
// STRUCTURE
//  - Shared package imm_pkg:
//    - state typedef imm_state_t {IDLE=1'b0, HOLD=1'b1}
//    - IMM_WIDTH=16, IMM_HALF=8
//    - function zext8(lower) -> {8'h00,lower}
//  - One sub-module: imm_out_slot (registered valid/ready slot; ports load, load_data, out_ready; provides in_ready).
//  - FSM, counter and merge mux live in the top level.
// TESTING
//  1. upper_in=16'hAB00, next cycle lower_in=8'hCD, out_ready=1 -> out_valid=1 one cycle later, out_data=16'hABCD, busy 1 then 0.
//  2. lower_in=8'h7F alone in IDLE -> out_data=16'h007F next cycle; upper and lower same cycle (16'h1200, 8'h34) -> 16'h1234.
//  3. upper_in=16'h5500, no lower, TIMEOUT=4 -> out_data=16'h5500 appears exactly 4 cycles after the accept; state IDLE.
//  4. out_ready=0, slot full, lower_valid=1 -> in_ready=0, input not consumed, out_data unchanged. Raise out_ready -> transfer, in_ready=1.
//  5. HOLD with held=8'h11, flush=1 with lower_valid=1 -> no output, state IDLE. Then lower 8'h22 -> 16'h0022.
//  6. reset_n low asynchronously mid-HOLD and with out_valid=1 -> out_valid=0, busy=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/imm_assemble_reg_pkg.sv
// Shared types, widths and helpers for the immediate-assembly stage.
package imm_pkg;

    localparam int IMM_WIDTH = 16;
    localparam int IMM_HALF  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } imm_state_t;

    // Zero-extend a lone low-byte immediate to the full constant width.
    function automatic logic [IMM_WIDTH-1:0] zext8(input logic [IMM_HALF-1:0] lower);
        return {8'h00, lower};
    endfunction

endpackage

// File: rtl/imm_assemble_reg_if.sv
// Input/output handshake bundle for imm_assemble_reg.
interface imm_assemble_reg_if #(
    parameter int WIDTH = 16,
    parameter int HALF  = 8
);
    logic             flush;
    logic             upper_valid;
    logic [WIDTH-1:0] upper_in;
    logic             lower_valid;
    logic [HALF-1:0]  lower_in;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             busy;

    modport master (
        output flush, upper_valid, upper_in, lower_valid, lower_in, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  flush, upper_valid, upper_in, lower_valid, lower_in, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/imm_assemble_reg_out_slot.sv
// Single-entry registered valid/ready output slot.
module imm_out_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             in_ready
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign in_ready  = !r_valid | out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    // Slot occupancy: flush empties, load (re)fills, a transfer without load empties.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/imm_assemble_reg.sv
// Merges an upper-immediate byte with the following low byte into a 16-bit
// constant; lone low bytes are zero-extended, lone uppers time out.
module imm_assemble_reg
    import imm_pkg::*;
#(
    parameter int WIDTH   = IMM_WIDTH,
    parameter int HALF    = IMM_HALF,
    parameter int TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    imm_assemble_reg_if.slave  bus
);
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    imm_state_t       r_state;
    logic [HALF-1:0]  r_held;
    logic [3:0]       r_cnt;

    logic             w_in_ready;
    logic             w_acc_u;
    logic             w_acc_l;
    logic             w_load;
    logic [WIDTH-1:0] w_load_data;
    logic [HALF-1:0]  w_upper_hi;
    logic             w_unused_upper_lo;

    assign w_upper_hi        = bus.upper_in[WIDTH-1:HALF];
    assign w_unused_upper_lo = ^bus.upper_in[HALF-1:0];
    assign w_acc_u           = bus.upper_valid & w_in_ready;
    assign w_acc_l           = bus.lower_valid & w_in_ready;
    assign bus.in_ready      = w_in_ready;
    assign bus.busy          = (r_state == HOLD);

    // Merge mux: decide whether this cycle completes a constant and what it is.
    always_comb begin
        w_load      = 1'b0;
        w_load_data = '0;
        if (!bus.flush) begin
            case (r_state)
                IDLE: begin
                    if (w_acc_l) begin
                        w_load      = 1'b1;
                        w_load_data = w_acc_u ? {w_upper_hi, bus.lower_in} : zext8(bus.lower_in);
                    end
                end
                HOLD: begin
                    if (w_acc_l) begin
                        w_load      = 1'b1;
                        w_load_data = w_acc_u ? {w_upper_hi, bus.lower_in} : {r_held, bus.lower_in};
                    end else if (!w_acc_u && r_cnt == CNT_LAST && w_in_ready) begin
                        w_load      = 1'b1;
                        w_load_data = {r_held, {HALF{1'b0}}};
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM and wait counter; counter saturates at CNT_LAST while the slot is busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_held  <= '0;
            r_cnt   <= '0;
        end else if (bus.flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc_u && !w_acc_l) begin
                        r_held  <= w_upper_hi;
                        r_cnt   <= '0;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_acc_l) begin
                        r_state <= IDLE;
                    end else if (w_acc_u) begin
                        r_held <= w_upper_hi;
                        r_cnt  <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        if (w_in_ready) begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    imm_out_slot #(
        .WIDTH(WIDTH)
    ) u_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (bus.flush),
        .load      (w_load),
        .load_data (w_load_data),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .in_ready  (w_in_ready)
    );
endmodule

// File: tb/tb_imm_assemble_reg.sv
// Directed bench for imm_assemble_reg with a per-cycle behavioural model.
module tb_imm_assemble_reg;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    imm_assemble_reg_if bus_if ();

    imm_assemble_reg #(
        .WIDTH   (16),
        .HALF    (8),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    // Behavioural model: one pending upper byte with an idle-cycle age, one output slot.
    logic        m_ov;
    logic [15:0] m_od;
    logic        m_pend;
    logic [7:0]  m_pbyte;
    int          m_idle;

    always @(posedge clk or negedge reset_n) begin : model
        logic        rdy;
        logic        au;
        logic        al;
        logic        emit;
        logic [15:0] val;
        if (!reset_n) begin
            m_ov = 1'b0; m_od = '0; m_pend = 1'b0; m_pbyte = '0; m_idle = 0;
        end else begin
            rdy  = !m_ov || bus_if.out_ready;
            emit = 1'b0;
            val  = m_od;
            if (bus_if.flush) begin
                m_pend = 1'b0; m_ov = 1'b0; m_idle = 0;
            end else begin
                au = bus_if.upper_valid && rdy;
                al = bus_if.lower_valid && rdy;
                if (al) begin
                    emit = 1'b1;
                    if (au)          val = {bus_if.upper_in[15:8], bus_if.lower_in};
                    else if (m_pend) val = {m_pbyte, bus_if.lower_in};
                    else             val = 16'(bus_if.lower_in);
                    m_pend = 1'b0;
                end else if (au) begin
                    m_pend = 1'b1; m_pbyte = bus_if.upper_in[15:8]; m_idle = 0;
                end else if (m_pend) begin
                    m_idle = m_idle + 1;
                    if (m_idle >= TIMEOUT && rdy) begin
                        emit = 1'b1; val = {m_pbyte, 8'h00}; m_pend = 1'b0;
                    end
                end
                if (emit) begin
                    m_ov = 1'b1; m_od = val;
                end else if (bus_if.out_ready) begin
                    m_ov = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_cmp();
        chk("mdl_out_valid", 32'(bus_if.out_valid), 32'(m_ov));
        chk("mdl_busy", 32'(bus_if.busy), 32'(m_pend));
        chk("mdl_in_ready", 32'(bus_if.in_ready), 32'(!m_ov || bus_if.out_ready));
        if (m_ov) chk("mdl_out_data", 32'(bus_if.out_data), 32'(m_od));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        model_cmp();
    endtask

    task automatic idle_in();
        bus_if.flush = 1'b0;
        bus_if.upper_valid = 1'b0;
        bus_if.lower_valid = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [15:0] d);
        chk({nm, "_valid"}, 32'(bus_if.out_valid), 32'd1);
        chk({nm, "_data"}, 32'(bus_if.out_data), 32'(d));
    endtask

    task automatic drive_u(input logic [15:0] u);
        bus_if.upper_valid = 1'b1; bus_if.upper_in = u;
    endtask

    task automatic drive_l(input logic [7:0] l);
        bus_if.lower_valid = 1'b1; bus_if.lower_in = l;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        idle_in();
        bus_if.upper_in = '0;
        bus_if.lower_in = '0;
        bus_if.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_out_data", 32'(bus_if.out_data), 32'd0);
        chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        reset_n = 1'b1;
        tick();

        // upper then lower on the next cycle
        drive_u(16'hAB00); tick();
        chk("t1_busy_hold", 32'(bus_if.busy), 32'd1);
        chk("t1_no_out", 32'(bus_if.out_valid), 32'd0);
        idle_in(); drive_l(8'hCD); tick();
        expect_out("t1_abcd", 16'hABCD);
        chk("t1_busy_idle", 32'(bus_if.busy), 32'd0);
        idle_in(); tick();
        chk("t1_drained", 32'(bus_if.out_valid), 32'd0);

        // lone lower, then both together back-to-back
        drive_l(8'h7F); tick();
        expect_out("t2_zext", 16'h007F);
        drive_u(16'h1200); drive_l(8'h34); tick();
        expect_out("t2_both", 16'h1234);
        idle_in(); tick();

        // timeout emission of a lone upper; low byte of upper_in ignored
        drive_u(16'h55A7); tick();
        idle_in();
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            chk("t3_wait_valid", 32'(bus_if.out_valid), 32'd0);
            chk("t3_wait_busy", 32'(bus_if.busy), 32'd1);
        end
        tick();
        expect_out("t3_timeout", 16'h5500);
        chk("t3_busy", 32'(bus_if.busy), 32'd0);
        tick();

        // backpressure: full slot refuses input
        bus_if.out_ready = 1'b0;
        drive_l(8'h99); tick();
        expect_out("t4_fill", 16'h0099);
        drive_l(8'h42); #1;
        chk("t4_in_ready_lo", 32'(bus_if.in_ready), 32'd0);
        tick();
        expect_out("t4_stable", 16'h0099);
        idle_in(); bus_if.out_ready = 1'b1; #1;
        chk("t4_in_ready_hi", 32'(bus_if.in_ready), 32'd1);
        tick();
        chk("t4_transfer", 32'(bus_if.out_valid), 32'd0);

        // flush abandons a held upper and a concurrent lower
        drive_u(16'h1100); tick();
        idle_in(); bus_if.flush = 1'b1; drive_l(8'h55); tick();
        chk("t5_flush_valid", 32'(bus_if.out_valid), 32'd0);
        chk("t5_flush_busy", 32'(bus_if.busy), 32'd0);
        idle_in(); drive_l(8'h22); tick();
        expect_out("t5_after", 16'h0022);
        idle_in(); tick();

        // HOLD: incoming upper wins over held; upper-only re-arms (last wins)
        drive_u(16'h6600); tick();
        drive_u(16'h7700); drive_l(8'h88); tick();
        expect_out("t6_upper_wins", 16'h7788);
        idle_in(); drive_u(16'h1300); tick();
        drive_u(16'h1400); tick();
        idle_in(); drive_l(8'h01); tick();
        expect_out("t6_last_wins", 16'h1401);
        idle_in(); tick();

        // asynchronous reset mid-HOLD
        drive_u(16'h2200); tick();
        idle_in();
        #2 reset_n = 1'b0;
        #1;
        chk("t7_hold_busy", 32'(bus_if.busy), 32'd0);
        chk("t7_hold_valid", 32'(bus_if.out_valid), 32'd0);
        #1 reset_n = 1'b1;
        tick();
        chk("t7_no_emit", 32'(bus_if.out_valid), 32'd0);

        // asynchronous reset with a pending output
        bus_if.out_ready = 1'b0;
        drive_l(8'h5A); tick();
        expect_out("t7_fill", 16'h005A);
        idle_in();
        #2 reset_n = 1'b0;
        #1;
        chk("t7_ov_valid", 32'(bus_if.out_valid), 32'd0);
        chk("t7_ov_busy", 32'(bus_if.busy), 32'd0);
        #1 reset_n = 1'b1;
        bus_if.out_ready = 1'b1;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
